// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline-stage state encoding and zero helper
package pipe_pkg;
  localparam int MAX_W = 256;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} pipe_state_e;
  function automatic logic [MAX_W-1:0] pipe_zero();
    return '0;
  endfunction
endpackage

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline register, skid-buffered or plain
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int ELASTIC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occupancy
);
  logic              xfer_in, xfer_out;
  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;
  assign out_valid = state_q != EMPTY;
  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_W'(pipe_zero());
  assign occupancy = state_q;
  // state and the output-facing main entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_data_q <= DATA_W'(pipe_zero());
      main_ctrl_q <= CTRL_W'(pipe_zero());
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
    end
  if (ELASTIC != 0) begin : g_skid
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q;
    assign in_ready = in_ready_q;
    // EMPTY/ONE/FULL transitions; skid catches the word that arrives under backpressure
    always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) state_d = EMPTY;
      else
        unique case (state_q)
          EMPTY: if (xfer_in) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
          ONE: if (xfer_in && xfer_out) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (xfer_in) begin
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (xfer_out) state_d = EMPTY;
          FULL: if (xfer_out) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
          default: state_d = EMPTY;
        endcase
    end
    // skid entry and registered ready, which never sees out_ready combinationally
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        skid_data_q <= DATA_W'(pipe_zero());
        skid_ctrl_q <= CTRL_W'(pipe_zero());
        in_ready_q  <= 1'b0;
      end else begin
        skid_data_q <= skid_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        in_ready_q  <= state_d != FULL;
      end
  end else begin : g_reg
    logic en_q;
    assign in_ready = en_q & (out_ready | !out_valid);
    // single register: load on accept, empty on drain without refill
    always_comb begin
      state_d     = flush ? EMPTY : xfer_in ? ONE : xfer_out ? EMPTY : state_q;
      main_data_d = (xfer_in && !flush) ? in_data : main_data_q;
      main_ctrl_d = (xfer_in && !flush) ? in_ctrl : main_ctrl_q;
    end
    // holds ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) en_q <= 1'b0;
      else en_q <= 1'b1;
  end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb_pipe_stage_elastic: scoreboard bench for elastic and plain stage variants
module tb_pipe_stage_elastic;
  logic clk = 1'b0, rst_n;
  always #5 clk = ~clk;
  logic e_iv, e_ir, e_ov, e_or, e_fl;
  logic [31:0] e_id, e_od;
  logic [3:0] e_ic, e_oc;
  logic [1:0] e_occ;
  logic r_iv, r_ir, r_ov, r_or, r_fl;
  logic [31:0] r_id, r_od;
  logic [3:0] r_ic, r_oc;
  logic [1:0] r_occ;
  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(4), .ELASTIC(1)) u_e (
    .clk(clk), .rst_n(rst_n), .in_valid(e_iv), .in_ready(e_ir), .in_data(e_id), .in_ctrl(e_ic),
    .out_valid(e_ov), .out_ready(e_or), .out_data(e_od), .out_ctrl(e_oc), .flush(e_fl), .occupancy(e_occ));
  pipe_stage_elastic #(.DATA_W(32), .CTRL_W(4), .ELASTIC(0)) u_r (
    .clk(clk), .rst_n(rst_n), .in_valid(r_iv), .in_ready(r_ir), .in_data(r_id), .in_ctrl(r_ic),
    .out_valid(r_ov), .out_ready(r_or), .out_data(r_od), .out_ctrl(r_oc), .flush(r_fl), .occupancy(r_occ));
  int n_cmp = 0, n_bad = 0;
  logic [35:0] eq[$];
  logic [35:0] exp_w;
  logic so_v, so_r, s_acc, s_out;
  logic [31:0] so_d;
  logic [3:0] so_c;
  logic [1:0] so_o;
  task automatic ce(input logic v, input logic [31:0] d, input logic [3:0] c, input logic ordy, input logic fl);
    @(negedge clk);
    e_iv = v; e_id = d; e_ic = c; e_or = ordy; e_fl = fl;
    #1;
    so_v = e_ov; so_r = e_ir; so_d = e_od; so_c = e_oc; so_o = e_occ;
    s_acc = v & e_ir & !fl;
    s_out = e_ov & ordy & !fl;
    @(posedge clk);
    #1;
  endtask
  task automatic cr(input logic v, input logic [31:0] d, input logic [3:0] c, input logic ordy);
    @(negedge clk);
    r_iv = v; r_id = d; r_ic = c; r_or = ordy; r_fl = 1'b0;
    #1;
    so_v = r_ov; so_r = r_ir; so_d = r_od; so_c = r_oc; so_o = r_occ;
    s_acc = v & r_ir;
    s_out = r_ov & ordy;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #2;
    n_cmp += 6;
    if ({e_ov, e_oc, e_occ} !== 7'd0) begin n_bad++; $display("FAIL reset_e_out: got v=%b c=%h occ=%0d want 0", e_ov, e_oc, e_occ); end
    if (e_od !== 32'd0) begin n_bad++; $display("FAIL reset_e_data: got %h want 0", e_od); end
    if (e_ir !== 1'b0) begin n_bad++; $display("FAIL reset_e_ready: got %b want 0", e_ir); end
    if (r_ir !== 1'b0) begin n_bad++; $display("FAIL reset_r_ready: got %b want 0", r_ir); end
    if ({r_ov, r_oc, r_occ, r_od} !== 39'd0) begin n_bad++; $display("FAIL reset_r_out: got v=%b c=%h occ=%0d d=%h want 0", r_ov, r_oc, r_occ, r_od); end
    if (e_occ !== 2'd0) begin n_bad++; $display("FAIL reset_occ: got %0d want 0", e_occ); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({e_ir, r_ir} !== 2'b00) begin n_bad++; $display("FAIL release_ready_early: got e=%b r=%b want 00", e_ir, r_ir); end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({e_ir, r_ir} !== 2'b11) begin n_bad++; $display("FAIL release_ready: got e=%b r=%b want 11", e_ir, r_ir); end
  endtask
  task automatic test_stream();
    for (int i = 0; i < 5; i++) begin
      ce(i < 3, 32'(i + 1), 4'h5, 1'b1, 1'b0);
      n_cmp += 2;
      if (so_v !== (i >= 1 && i <= 3)) begin n_bad++; $display("FAIL stream_valid[%0d]: got %b want %b", i, so_v, (i >= 1 && i <= 3)); end
      if (so_r !== 1'b1) begin n_bad++; $display("FAIL stream_ready[%0d]: got %b want 1", i, so_r); end
      if (so_v) begin
        n_cmp++;
        if (so_o !== 2'd1) begin n_bad++; $display("FAIL stream_occ[%0d]: got %0d want 1", i, so_o); end
      end
      if (s_out) begin
        n_cmp++;
        if (eq.size() == 0) begin n_bad++; $display("FAIL stream_sb: unexpected %h", so_d); end
        else begin exp_w = eq.pop_front(); if ({so_c, so_d} !== exp_w) begin n_bad++; $display("FAIL stream_sb: got %h want %h", {so_c, so_d}, exp_w); end end
      end
      if (s_acc) eq.push_back({4'h5, 32'(i + 1)});
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] words [3] = '{32'hA, 32'hB, 32'hC};
    int idx = 0, outs = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      ce(idx < 3, idx < 3 ? words[idx] : 32'h0, 4'h9, cyc >= 3, 1'b0);
      if (cyc == 1 || cyc == 2) begin
        n_cmp++;
        if (so_d !== 32'hA) begin n_bad++; $display("FAIL bp_hold[%0d]: got %h want a", cyc, so_d); end
      end
      if (cyc == 1) begin
        n_cmp++;
        if (so_r !== 1'b1) begin n_bad++; $display("FAIL bp_ready_one: got %b want 1", so_r); end
      end
      if (cyc == 2) begin
        n_cmp += 2;
        if (so_r !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b want 0", so_r); end
        if (so_o !== 2'd2) begin n_bad++; $display("FAIL bp_occ_full: got %0d want 2", so_o); end
      end
      if (s_out) begin
        n_cmp++;
        outs++;
        if (eq.size() == 0) begin n_bad++; $display("FAIL bp_sb: unexpected %h", so_d); end
        else begin exp_w = eq.pop_front(); if ({so_c, so_d} !== exp_w) begin n_bad++; $display("FAIL bp_sb: got %h want %h", {so_c, so_d}, exp_w); end end
      end
      if (s_acc) begin eq.push_back({4'h9, words[idx]}); idx++; end
    end
    n_cmp++;
    if (outs != 3 || idx != 3) begin n_bad++; $display("FAIL bp_count: got out=%0d in=%0d want 3/3", outs, idx); end
  endtask
  task automatic test_flush();
    ce(1'b1, 32'h11, 4'h3, 1'b0, 1'b0);
    ce(1'b1, 32'h12, 4'h3, 1'b0, 1'b0);
    ce(1'b1, 32'hD, 4'h3, 1'b0, 1'b1);
    n_cmp += 2;
    if (so_o !== 2'd2) begin n_bad++; $display("FAIL flush_pre_occ: got %0d want 2", so_o); end
    if (so_r !== 1'b0) begin n_bad++; $display("FAIL flush_pre_ready: got %b want 0", so_r); end
    ce(1'b1, 32'hE, 4'h7, 1'b1, 1'b1);
    n_cmp += 2;
    if ({so_v, so_c, so_o} !== 7'd0) begin n_bad++; $display("FAIL flush_post: got v=%b c=%h occ=%0d want 0", so_v, so_c, so_o); end
    if (so_r !== 1'b1) begin n_bad++; $display("FAIL flush_post_ready: got %b want 1", so_r); end
    for (int i = 0; i < 3; i++) begin
      ce(1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
      n_cmp++;
      if (so_v !== 1'b0) begin n_bad++; $display("FAIL flush_leak[%0d]: got data %h valid", i, so_d); end
    end
  endtask
  task automatic test_bubble();
    for (int i = 0; i < 2; i++) begin
      ce(1'b0, 32'h0, 4'hF, 1'b1, 1'b0);
      n_cmp++;
      if ({so_v, so_c} !== 5'd0) begin n_bad++; $display("FAIL bubble[%0d]: got v=%b c=%h want 0/0", i, so_v, so_c); end
    end
  endtask
  task automatic test_async_reset();
    ce(1'b1, 32'h21, 4'h6, 1'b0, 1'b0);
    ce(1'b1, 32'h22, 4'h6, 1'b0, 1'b0);
    @(negedge clk);
    e_iv = 1'b0;
    #1;
    n_cmp++;
    if (e_occ !== 2'd2) begin n_bad++; $display("FAIL arst_pre_occ: got %0d want 2", e_occ); end
    rst_n = 1'b0;
    #1;
    eq.delete();
    n_cmp += 2;
    if ({e_ov, e_occ, e_oc, e_ir} !== 8'd0) begin n_bad++; $display("FAIL arst_clear: got v=%b occ=%0d c=%h rdy=%b want 0", e_ov, e_occ, e_oc, e_ir); end
    if (e_od !== 32'd0) begin n_bad++; $display("FAIL arst_data: got %h want 0", e_od); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({e_ir, e_ov, e_occ} !== 4'b1000) begin n_bad++; $display("FAIL arst_release: got rdy=%b v=%b occ=%0d want 1/0/0", e_ir, e_ov, e_occ); end
  endtask
  task automatic test_reg_mode();
    logic ordy;
    int idx = 0, outs = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      ordy = cyc >= 12 ? 1'b1 : (cyc % 3 != 1);
      cr(cyc < 12, 32'h100 + 32'(idx), 4'hA, ordy);
      n_cmp += 2;
      if (so_r !== (ordy | !so_v)) begin n_bad++; $display("FAIL reg_ready[%0d]: got %b want %b", cyc, so_r, ordy | !so_v); end
      if (so_o !== {1'b0, so_v}) begin n_bad++; $display("FAIL reg_occ[%0d]: got %0d want %0d", cyc, so_o, so_v); end
      if (s_out) begin
        n_cmp++;
        outs++;
        if (eq.size() == 0) begin n_bad++; $display("FAIL reg_sb: unexpected %h", so_d); end
        else begin exp_w = eq.pop_front(); if ({so_c, so_d} !== exp_w) begin n_bad++; $display("FAIL reg_sb: got %h want %h", {so_c, so_d}, exp_w); end end
      end
      if (s_acc) begin eq.push_back({4'hA, 32'h100 + 32'(idx)}); idx++; end
    end
    n_cmp++;
    if (outs != idx || idx < 6) begin n_bad++; $display("FAIL reg_count: got out=%0d in=%0d want equal, >=6", outs, idx); end
  endtask
  initial begin
    rst_n = 1'b0;
    {e_iv, e_or, e_fl, e_id, e_ic} = '0;
    {r_iv, r_or, r_fl, r_id, r_ic} = '0;
    test_reset();
    test_stream();
    test_bubble();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_reg_mode();
    n_cmp++;
    if (eq.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d entries want 0", eq.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
